// File: rtl/ahbmtx_pkg.sv
// Shared bus-matrix definitions: AHB encodings and the decoder address split.
package ahbmtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    // Lowest address bit the slave-port decoder looks at.
    localparam int DEC_LSB = 10;

    // Address-phase controls captured from a master.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [3:0]  prot;
    } addr_ctrl_t;

endpackage

// File: rtl/ahbmtx_in_stg_s4.sv
// Input stage for slave port S4: forwards the master's address phase to the
// decoder, parks one transfer when the target output stage is busy, and
// stalls the master until that parked transfer has been issued.
module ahbmtx_in_stg_s4
    import ahbmtx_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DEC_LSB = ahbmtx_pkg::DEC_LSB
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HSELS,
    input  logic [ADDR_W-1:0]         HADDRS,
    input  logic [1:0]                HTRANSS,
    input  logic                      HWRITES,
    input  logic [2:0]                HSIZES,
    input  logic [2:0]                HBURSTS,
    input  logic [3:0]                HPROTS,
    input  logic                      HREADYS,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic                      sel_dec,
    output logic [ADDR_W-DEC_LSB-1:0] decode_addr_dec,
    output logic [1:0]                trans_dec,
    output logic                      ready_dec,
    output logic [ADDR_W-1:0]         addr_op,
    output logic                      write_op,
    output logic [2:0]                size_op,
    output logic [2:0]                burst_op,
    output logic [3:0]                prot_op,
    output logic                      held_tran_op,
    input  logic                      active_dec,
    input  logic                      readyout_dec,
    input  logic [1:0]                resp_dec
);

    addr_ctrl_t cur_ctrl;
    addr_ctrl_t held_ctrl;
    addr_ctrl_t fwd_ctrl;
    logic       held_valid;
    logic       data_pend;
    logic       sample;
    logic       load_hold;
    logic       held_issue;
    logic       issue;

    // Gather the live master address phase into one bundle.
    always_comb begin
        cur_ctrl.addr  = HADDRS;
        cur_ctrl.trans = HTRANSS;
        cur_ctrl.write = HWRITES;
        cur_ctrl.size  = HSIZES;
        cur_ctrl.burst = HBURSTS;
        cur_ctrl.prot  = HPROTS;
    end

    // Transfer qualification. IDLE/BUSY never reach the holding register, and
    // a held transfer blocks sampling (the master is stalled anyway).
    always_comb begin
        sample     = HSELS & HREADYS & HTRANSS[1] & ~held_valid;
        load_hold  = sample & ~active_dec;
        held_issue = held_valid & active_dec & readyout_dec;
        issue      = (sample & active_dec) | held_issue;
    end

    // Holding register captures a transfer that lost arbitration.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_ctrl <= '0;
        end else if (load_hold) begin
            held_ctrl <= cur_ctrl;
        end
    end

    // Hold-valid and data-phase-pending tracking.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_valid <= 1'b0;
            data_pend  <= 1'b0;
        end else begin
            if (load_hold) begin
                held_valid <= 1'b1;
            end else if (held_issue) begin
                held_valid <= 1'b0;
            end

            if (load_hold) begin
                data_pend <= 1'b0;
            end else if (issue) begin
                data_pend <= 1'b1;
            end else if (readyout_dec) begin
                data_pend <= 1'b0;
            end
        end
    end

    // Forwarding mux plus ready/response steering back to the master.
    always_comb begin
        fwd_ctrl        = held_valid ? held_ctrl : cur_ctrl;
        sel_dec         = held_valid | HSELS;
        decode_addr_dec = fwd_ctrl.addr[ADDR_W-1:DEC_LSB];
        trans_dec       = fwd_ctrl.trans;
        addr_op         = fwd_ctrl.addr;
        write_op        = fwd_ctrl.write;
        size_op         = fwd_ctrl.size;
        burst_op        = fwd_ctrl.burst;
        prot_op         = fwd_ctrl.prot;
        held_tran_op    = held_valid;
        ready_dec       = held_valid ? readyout_dec : HREADYS;
        HREADYOUTS      = 1'b1;
        HRESPS          = HRESP_OKAY;
        if (held_valid) begin
            HREADYOUTS = 1'b0;
        end else if (data_pend) begin
            HREADYOUTS = readyout_dec;
            HRESPS     = resp_dec;
        end
    end

endmodule

// File: tb/tb_ahbmtx_in_stg_s4.sv
// Bench for the S4 input stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the port.
module tb_ahbmtx_in_stg_s4;
    import ahbmtx_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSELS;
    logic [31:0] HADDRS;
    logic [1:0]  HTRANSS;
    logic        HWRITES;
    logic [2:0]  HSIZES;
    logic [2:0]  HBURSTS;
    logic [3:0]  HPROTS;
    logic        HREADYS;
    logic        HREADYOUTS;
    logic [1:0]  HRESPS;
    logic        sel_dec;
    logic [21:0] decode_addr_dec;
    logic [1:0]  trans_dec;
    logic        ready_dec;
    logic [31:0] addr_op;
    logic        write_op;
    logic [2:0]  size_op;
    logic [2:0]  burst_op;
    logic [3:0]  prot_op;
    logic        held_tran_op;
    logic        active_dec;
    logic        readyout_dec;
    logic [1:0]  resp_dec;

    int checks = 0;
    int errors = 0;

    // Reference model: at most one parked transfer, plus "a data phase is owed".
    addr_ctrl_t hq[$];
    bit         pend;

    always #5 HCLK = ~HCLK;

    ahbmtx_in_stg_s4 dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
        .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
        .HPROTS(HPROTS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
        .sel_dec(sel_dec), .decode_addr_dec(decode_addr_dec), .trans_dec(trans_dec),
        .ready_dec(ready_dec), .addr_op(addr_op), .write_op(write_op), .size_op(size_op),
        .burst_op(burst_op), .prot_op(prot_op), .held_tran_op(held_tran_op),
        .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic addr_ctrl_t live();
        addr_ctrl_t t;
        t.addr = HADDRS; t.trans = HTRANSS; t.write = HWRITES;
        t.size = HSIZES; t.burst = HBURSTS; t.prot = HPROTS;
        return t;
    endfunction

    function automatic logic m_hready();
        if (hq.size() != 0) return 1'b0;
        return pend ? readyout_dec : 1'b1;
    endfunction

    task automatic check_all();
        addr_ctrl_t f;
        bit holding;
        holding = (hq.size() != 0);
        f = holding ? hq[0] : live();
        check("hreadyout", 64'(HREADYOUTS), 64'(m_hready()));
        check("hresp", 64'(HRESPS), 64'((!holding && pend) ? resp_dec : HRESP_OKAY));
        check("sel_dec", 64'(sel_dec), 64'(holding ? 1'b1 : HSELS));
        check("decode_addr", 64'(decode_addr_dec), 64'(f.addr >> 10));
        check("trans_dec", 64'(trans_dec), 64'(f.trans));
        check("ready_dec", 64'(ready_dec), 64'(holding ? readyout_dec : HREADYS));
        check("op_ctrl", 64'({addr_op, write_op, size_op, burst_op, prot_op}),
              64'({f.addr, f.write, f.size, f.burst, f.prot}));
        check("held_tran", 64'(held_tran_op), 64'(holding));
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit holding, accepted;
        holding  = (hq.size() != 0);
        accepted = HSELS && HREADYS && (HTRANSS == HTRANS_NONSEQ || HTRANSS == HTRANS_SEQ) && !holding;
        if (accepted && !active_dec) begin
            hq.push_back(live());
            pend = 0;
        end else if (holding && active_dec && readyout_dec) begin
            void'(hq.pop_front());
            pend = 1;
        end else if (accepted) begin
            pend = 1;
        end else if (readyout_dec) begin
            pend = 0;
        end
    endtask

    // Bus HREADY is the port's own HREADYOUT, as in the matrix.
    task automatic settle();
        HREADYS = m_hready();
        #1;
        check_all();
    endtask

    task automatic adv();
        @(posedge HCLK);
        if (HRESETn) model_step();
        @(negedge HCLK);
    endtask

    task automatic cycle();
        settle();
        adv();
    endtask

    task automatic master(input logic sel, input logic [31:0] a, input logic [1:0] tr, input logic wr);
        HSELS = sel; HADDRS = a; HTRANSS = tr; HWRITES = wr;
        HSIZES = 3'd2; HBURSTS = 3'd1; HPROTS = 4'h3;
    endtask

    initial begin
        bit last_rdy;
        HRESETn = 1'b0;
        master(1'b0, 32'h0, HTRANS_IDLE, 1'b0);
        HSIZES = 3'd0; HBURSTS = 3'd0; HPROTS = 4'h0;
        HREADYS = 1'b0; active_dec = 1'b0; readyout_dec = 1'b1; resp_dec = 2'b00;
        pend = 0;
        #3;
        check("rst_hreadyout", 64'(HREADYOUTS), 64'(1));
        check("rst_hresp", 64'(HRESPS), 64'(0));
        check("rst_held", 64'(held_tran_op), 64'(0));
        check("rst_sel", 64'(sel_dec), 64'(0));
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Pass-through write, then a waited data phase.
        active_dec = 1; readyout_dec = 1;
        master(1'b1, 32'h4003_0000, HTRANS_NONSEQ, 1'b1);
        settle();
        check("s1_dec", 64'(decode_addr_dec), 64'(22'h1000C0));
        check("s1_trans", 64'(trans_dec), 64'(2'b10));
        adv();
        master(1'b1, 32'h0, HTRANS_IDLE, 1'b0);
        readyout_dec = 0;
        settle();
        check("s1_wait", 64'(HREADYOUTS), 64'(0));
        adv();
        readyout_dec = 1;
        cycle();

        // Lost arbitration: park, stall three cycles, then issue.
        active_dec = 0;
        master(1'b1, 32'h5000_0004, HTRANS_NONSEQ, 1'b0);
        cycle();
        master(1'b1, 32'h1234_5678, HTRANS_NONSEQ, 1'b1);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("s2_stall", 64'(HREADYOUTS), 64'(0));
            check("s2_addr", 64'(addr_op), 64'(32'h5000_0004));
            adv();
        end
        active_dec = 1; readyout_dec = 1;
        cycle();
        master(1'b1, 32'h0, HTRANS_IDLE, 1'b0);
        readyout_dec = 0;
        settle();
        check("s2_issued", 64'(held_tran_op), 64'(0));
        check("s2_dphase", 64'(HREADYOUTS), 64'(0));
        adv();
        readyout_dec = 1;
        cycle();

        // Parked SEQ keeps its HTRANS.
        active_dec = 0;
        master(1'b1, 32'h6000_0010, HTRANS_SEQ, 1'b0);
        cycle();
        master(1'b0, 32'h0, HTRANS_IDLE, 1'b0);
        settle();
        check("s3_trans", 64'(trans_dec), 64'(2'b11));
        check("s3_sel", 64'(sel_dec), 64'(1));
        adv();
        active_dec = 1;
        cycle();
        cycle();

        // Selected IDLE with no grant is not parked.
        active_dec = 0;
        master(1'b1, 32'h7000_0000, HTRANS_IDLE, 1'b0);
        cycle();
        settle();
        check("s4_ready", 64'(HREADYOUTS), 64'(1));
        check("s4_held", 64'(held_tran_op), 64'(0));
        adv();

        // Two-cycle ERROR passes through; nothing parks during its first cycle.
        active_dec = 1; readyout_dec = 1;
        master(1'b1, 32'h4000_0100, HTRANS_NONSEQ, 1'b1);
        cycle();
        active_dec = 0; readyout_dec = 0; resp_dec = HRESP_ERROR;
        master(1'b1, 32'h4000_0200, HTRANS_NONSEQ, 1'b1);
        settle();
        check("s5_resp1", 64'(HRESPS), 64'(2'b01));
        check("s5_rdy1", 64'(HREADYOUTS), 64'(0));
        adv();
        readyout_dec = 1;
        master(1'b1, 32'h0, HTRANS_IDLE, 1'b0);
        settle();
        check("s5_resp2", 64'(HRESPS), 64'(2'b01));
        check("s5_rdy2", 64'(HREADYOUTS), 64'(1));
        check("s5_nohold", 64'(held_tran_op), 64'(0));
        adv();
        resp_dec = HRESP_OKAY;
        cycle();

        // Reset while a transfer is parked.
        active_dec = 0;
        master(1'b1, 32'h5555_0000, HTRANS_NONSEQ, 1'b0);
        cycle();
        settle();
        check("s6_held", 64'(held_tran_op), 64'(1));
        #1;
        HRESETn = 1'b0;
        #1;
        check("s6_rst_rdy", 64'(HREADYOUTS), 64'(1));
        check("s6_rst_held", 64'(held_tran_op), 64'(0));
        hq.delete();
        pend = 0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        active_dec = 1; readyout_dec = 1;
        master(1'b1, 32'h4003_0000, HTRANS_NONSEQ, 1'b1);
        settle();
        check("s6_dec", 64'(decode_addr_dec), 64'(22'h1000C0));
        check("s6_passthru", 64'(held_tran_op), 64'(0));
        adv();

        // Random traffic; master inputs stay stable while the bus is stalled.
        last_rdy = 1;
        for (int n = 0; n < 400; n++) begin
            if (last_rdy) begin
                HSELS   = ($urandom_range(3, 0) != 0);
                HADDRS  = $urandom;
                HTRANSS = 2'($urandom_range(3, 0));
                HWRITES = 1'($urandom_range(1, 0));
                HSIZES  = 3'($urandom_range(7, 0));
                HBURSTS = 3'($urandom_range(7, 0));
                HPROTS  = 4'($urandom_range(15, 0));
            end
            active_dec   = 1'($urandom_range(1, 0));
            readyout_dec = ($urandom_range(2, 0) != 0);
            resp_dec     = 2'($urandom_range(1, 0));
            settle();
            last_rdy = HREADYS;
            adv();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahbmtx_in_stg_s4.md
Name: ahbmtx_in_stg_s4

Overview:
- Bus-matrix input stage for slave port S4; sits directly upstream of the S4 address decoder.
- Registers/forwards the master's address-phase controls to the decoder and to the output stages.
- Holds one transfer in a holding register when the targeted output stage is not active (arbitration lost). Inserts wait states to the master until that transfer is issued.

Parameters:
- ADDR_W, 32, address width. Only 32 is supported.
- DEC_LSB, 10, lowest address bit forwarded on decode_addr_dec.

Ports:
- HCLK  in  1  AHB clock
- HRESETn  in  1  async active-low reset
- HSELS  in  1  port select from master
- HADDRS  in  32  address
- HTRANSS  in  2  transfer type
- HWRITES  in  1  write
- HSIZES  in  3  size
- HBURSTS  in  3  burst
- HPROTS  in  4  protection
- HREADYS  in  1  bus HREADY seen by master
- HREADYOUTS  out  1  ready to master
- HRESPS  out  2  response to master
- sel_dec  out  1  select to decoder
- decode_addr_dec  out  22  addr[31:10] to decoder
- trans_dec  out  2  HTRANS to decoder
- ready_dec  out  1  HREADY to decoder / output stages
- addr_op  out  32  forwarded address
- write_op  out  1  forwarded write
- size_op  out  3  forwarded size
- burst_op  out  3  forwarded burst
- prot_op  out  4  forwarded protection
- held_tran_op  out  1  forwarded transfer is from holding register
- active_dec  in  1  target output stage currently grants S4
- readyout_dec  in  1  selected data-phase HREADYOUT
- resp_dec  in  2  selected data-phase HRESP

Behaviour:
Reset:
- Clears held_valid, all holding registers and data_pend.
- Outputs settle to pass-through of zeroed inputs: HREADYOUTS=1, HRESPS=2'b00, held_tran_op=0.

Sampling:
- A transfer is sampled on a rising HCLK when HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ) & ~held_valid.
- If active_dec=0 in that cycle, load the holding register: addr, trans, write, size, burst, prot. Set held_valid=1 and data_pend=0.
- If active_dec=1, the transfer is passed through unchanged.

Muxing:
- held_valid=1: all *_dec/*_op outputs come from the holding register; sel_dec=1; held_tran_op=1.
- held_valid=0: outputs come from the HADDRS/HTRANSS/... inputs; sel_dec=HSELS; held_tran_op=0.

Ready and response:
- ready_dec = held_valid ? readyout_dec : HREADYS.
- HREADYOUTS = held_valid ? 0 : (data_pend ? readyout_dec : 1).
- HRESPS = held_valid ? OKAY : (data_pend ? resp_dec : OKAY).
- data_pend is set when a transfer (direct or held) is issued.
- data_pend is cleared when readyout_dec=1 and no new transfer is issued in the same cycle.

Held issue:
- Occurs when held_valid & active_dec & readyout_dec at a rising edge.
- held_valid clears next cycle and data_pend is set.
- Latency from active_dec rising: 1 cycle minimum.

Boundary cases:
- IDLE/BUSY with HSELS=1 is never held. An IDLE passes through and must get a zero-wait OKAY via the decoder.
- HSELS=0 forces sel_dec=0 unless held_valid=1.
- Held transfer keeps its original HTRANS; SEQ is not converted.
- Master inputs are ignored while held_valid=1; they are AHB-stable because HREADYOUTS=0.
- Two-cycle ERROR from resp_dec during the data phase passes through unchanged. The holding register never loads on the ERROR first cycle because HREADYS=0 then.
- Simultaneous held issue and new sample cannot occur, since HREADYS=0 while held.
- Reset mid-hold drops the held transfer and returns HREADYOUTS=1 asynchronously.

Decomposition:
- Shared package ahbmtx_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ
  - HRESP OKAY/ERROR
  - DEC_LSB
- No sub-module; the holding register is inline.

Test Plan:
1. Pass-through: active_dec=1, NONSEQ HADDRS=0x4003_0000 write -> same cycle decode_addr_dec=22'h1000C0, trans_dec=2'b10, held_tran_op=0; HREADYOUTS follows readyout_dec next cycle.
2. Hold: active_dec=0 on NONSEQ read 0x5000_0004 -> next cycle held_valid=1, HREADYOUTS=0, addr_op=0x5000_0004. Raise active_dec with readyout_dec=1 after 3 cycles -> issue; one cycle later HREADYOUTS=readyout_dec.
3. Held SEQ: active_dec=0 on SEQ -> trans_dec=2'b11 held; held_tran_op=1 until issue.
4. IDLE with active_dec=0 -> no hold; HREADYOUTS=1, HRESPS=OKAY.
5. ERROR: resp_dec=2'b01 for 2 cycles with readyout_dec 0 then 1 -> HRESPS=2'b01 both cycles, HREADYOUTS 0 then 1, no hold load.
6. Reset asserted while held_valid=1 -> immediately HREADYOUTS=1, held_tran_op=0; after release, next NONSEQ behaves as in scenario 1.
